// File: rtl/forward_track_unit_pkg.sv
// Shared types and encodings for the EX-stage forwarding / load-use hazard unit.
// Tag dst is stored at a fixed width; REG_W must not exceed TAG_REG_W.
package forward_track_unit_pkg;

  localparam int TAG_REG_W = 8;
  localparam int FWD_NONE  = 0;

  typedef logic [TAG_REG_W-1:0] tag_reg_t;

  typedef struct packed {
    logic     valid;
    tag_reg_t dst;
    logic     we;
    logic     is_load;
  } tag_t;

  function automatic int sel_w(input int depth);
    return (depth + 1 > 1) ? $clog2(depth + 1) : 1;
  endfunction

  // Stage k of the post-EX pipeline is reported as code k+1.
  function automatic int stage_code(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/forward_track_unit_select_lane.sv
// One operand lane: priority match over the tracked tags (youngest wins) and data mux.
module forward_select_lane
  import forward_track_unit_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int REG_W            = 5,
  parameter int DEPTH            = 3,
  parameter int LOAD_READY_STAGE = 1,
  localparam int SEL_W           = sel_w(DEPTH)
) (
  input  logic [REG_W-1:0]        src_reg,
  input  logic [DATA_W-1:0]       src_data,
  input  tag_t [DEPTH-1:0]        tags,
  input  logic [DEPTH*DATA_W-1:0] stage_data,
  output logic [SEL_W-1:0]        fwd_sel,
  output logic [DATA_W-1:0]       fwd_data,
  output logic                    not_ready
);

  always_comb begin
    fwd_sel   = SEL_W'(FWD_NONE);
    fwd_data  = src_data;
    not_ready = 1'b0;
    // Walk oldest to youngest so the lowest matching stage is the final assignment.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (tags[k].valid && tags[k].we && (src_reg != '0) &&
          (tags[k].dst == tag_reg_t'(src_reg))) begin
        fwd_sel   = SEL_W'(stage_code(k));
        fwd_data  = stage_data[k*DATA_W +: DATA_W];
        not_ready = tags[k].is_load && (k < LOAD_READY_STAGE);
      end
    end
  end

endmodule

// File: rtl/forward_track_unit.sv
// EX-stage forwarding and load-use hazard unit: tracks destination tags of
// in-flight instructions, selects forwarded operands and counts stall cycles.
module forward_track_unit
  import forward_track_unit_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int REG_W            = 5,
  parameter int NUM_SRC          = 2,
  parameter int DEPTH            = 3,
  parameter int LOAD_READY_STAGE = 1,
  parameter int COUNT_W          = 16,
  localparam int SEL_W           = sel_w(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      exValid,
  input  logic [NUM_SRC*REG_W-1:0]  exSrcReg,
  input  logic [NUM_SRC*DATA_W-1:0] exSrcData,
  input  logic [REG_W-1:0]          exDstReg,
  input  logic                      exWrEnable,
  input  logic                      exIsLoad,
  input  logic [DEPTH*DATA_W-1:0]   stageData,
  input  logic                      flush,
  input  logic                      stallExt,
  input  logic                      counterClear,
  output logic [NUM_SRC*DATA_W-1:0] fwdData,
  output logic [NUM_SRC*SEL_W-1:0]  fwdSel,
  output logic                      hazardStall,
  output logic [COUNT_W-1:0]        stallCount
);

  tag_t [DEPTH-1:0]   tag_q, tag_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [NUM_SRC-1:0] not_ready;
  logic               ex_issue;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    forward_select_lane #(
      .DATA_W           (DATA_W),
      .REG_W            (REG_W),
      .DEPTH            (DEPTH),
      .LOAD_READY_STAGE (LOAD_READY_STAGE)
    ) u_lane (
      .src_reg    (exSrcReg[i*REG_W +: REG_W]),
      .src_data   (exSrcData[i*DATA_W +: DATA_W]),
      .tags       (tag_q),
      .stage_data (stageData),
      .fwd_sel    (fwdSel[i*SEL_W +: SEL_W]),
      .fwd_data   (fwdData[i*DATA_W +: DATA_W]),
      .not_ready  (not_ready[i])
    );
  end

  assign hazardStall = (|not_ready) && exValid && !flush;
  assign ex_issue    = exValid && !flush && !hazardStall;
  assign stallCount  = count_q;

  always_comb begin
    tag_d = tag_q;
    if (!stallExt) begin
      for (int k = 1; k < DEPTH; k++) begin
        tag_d[k] = tag_q[k-1];
      end
      // A stalled or killed EX slot becomes a bubble in stage 0.
      tag_d[0] = '0;
      if (ex_issue) begin
        tag_d[0].valid   = 1'b1;
        tag_d[0].dst     = tag_reg_t'(exDstReg);
        tag_d[0].we      = exWrEnable;
        tag_d[0].is_load = exIsLoad;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (counterClear) begin
      count_d = '0;
    end else if (hazardStall && !stallExt && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q   <= '0;
      count_q <= '0;
    end else begin
      tag_q   <= tag_d;
      count_q <= count_d;
    end
  end

endmodule

// File: doc/forward_track_unit.md
Name: forward_track_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the EX stage of the pipelined core.
- Holds its own DEPTH-entry shift pipeline of destination tags (valid, dst, we, isLoad) for instructions past EX.
- For each of NUM_SRC EX operands, selects the youngest matching in-flight result, or the ID/EX latched value when nothing matches.
- Raises a load-use stall when the matching result is not yet available, and keeps a saturating count of stall cycles.

Parameters:
DATA_W, 32, operand/result width
REG_W, 5, register index width
NUM_SRC, 2, number of EX source operands
DEPTH, 3, tracked post-EX stages (stage 0 = EX/MEM, stage DEPTH-1 = writeback)
LOAD_READY_STAGE, 1, first stage index at which a load result is valid in stageData; 1..DEPTH-1
COUNT_W, 16, stall counter width

Ports:
clk  input  1  clock
rst  input  1  reset (asynchronous, active-high)
exValid  input  1  EX holds a real instruction
exSrcReg  input  NUM_SRC*REG_W  source indices, operand i at [i*REG_W +: REG_W]
exSrcData  input  NUM_SRC*DATA_W  operand values from the ID/EX latch
exDstReg  input  REG_W  EX destination index
exWrEnable  input  1  EX instruction writes the register file
exIsLoad  input  1  EX instruction is a load
stageData  input  DEPTH*DATA_W  result held in each post-EX pipeline register, stage k at [k*DATA_W +: DATA_W]
flush  input  1  kill the EX instruction this cycle
stallExt  input  1  global freeze (memory wait)
counterClear  input  1  synchronous clear of stallCount
fwdData  output  NUM_SRC*DATA_W  selected operand values
fwdSel  output  NUM_SRC*SEL_W  per operand: 0 = no forward, k+1 = forwarded from stage k; SEL_W = $clog2(DEPTH+1)
hazardStall  output  1  hold IF/ID/EX, insert bubble
stallCount  output  COUNT_W  saturating count of hazardStall cycles

Behaviour:
- Reset (async, rst=1): all entries invalid, stallCount=0. With entries invalid: fwdSel=0, fwdData=exSrcData, hazardStall=0.
- Entry k matches operand i when all of the following hold: entry valid, entry we=1, entry dst==exSrcReg[i], exSrcReg[i]!=0.
- Register 0 is never forwarded and never stalls.
- Selection is combinational with zero-cycle latency:
  - The lowest matching k wins (youngest).
  - fwdSel[i]=k+1 and fwdData[i]=stageData[k].
  - No match: fwdSel[i]=0 and fwdData[i]=exSrcData[i].
- Raw hazard: any operand's winning entry has isLoad=1 and k < LOAD_READY_STAGE.
- hazardStall = raw hazard & exValid & !flush.
- On a stalled operand, fwdSel still reports the stage and fwdData reports the not-ready stageData. The consumer must not use either while hazardStall=1.
- State update at posedge clk, in priority order:
  1. stallExt=1: entries and stallCount hold. hazardStall still reflects the current match.
  2. Otherwise, entries shift k -> k+1 and entry DEPTH-1 is discarded.
  3. Stage 0 loads the EX tag {1, exDstReg, exWrEnable, exIsLoad} only when exValid & !flush & !hazardStall. Otherwise stage 0 loads a bubble (valid=0).
- stallCount update:
  - counterClear=1 sets it to 0, regardless of stallExt.
  - Otherwise it increments when hazardStall=1 and stallExt=0.
  - It saturates at all-ones and never wraps.
- A stalled instruction re-evaluates next cycle. After the stall the load has moved to stage 1, so the stall lasts exactly LOAD_READY_STAGE - k cycles.
- An async reset during a stall clears everything immediately. hazardStall drops in the same cycle.

Decomposition:
- Shared package holds:
  - the tag struct {valid, dst, we, isLoad};
  - the SEL_W function;
  - the fwdSel encodings (FWD_NONE=0; stage codes 1..DEPTH, superseding the fixed EXMEM/MEMWB codes).
- One sub-module, forward_select_lane, instantiated NUM_SRC times. It does the priority match and mux for one operand and emits fwdSel, fwdData and a per-lane notReady bit.
- The top holds the tag shift pipeline, stall gating and counter.

Test Plan (defaults):
1. Assert then release rst, exSrcData={0x22,0x11} -> fwdSel=0 both, fwdData={0x22,0x11}, hazardStall=0, stallCount=0.
2. ALU writes r3; next cycle EX reads r3 on operand 0, stageData[0]=0x1234 -> fwdSel[0]=1, fwdData[0]=0x1234. Next cycle the reader reads r3 again with stageData[1]=0x1234 -> fwdSel=2.
3. Two writes to r3 in consecutive cycles, then a read of r3 with stageData[0]=0xA, stageData[1]=0xB -> fwdSel=1, fwdData=0xA (youngest wins).
4. Load r5, then add reading r5 -> hazardStall=1 for one cycle and stallCount=1. Next cycle fwdSel=2, fwdData=stageData[1], hazardStall=0.
5. Write r0 with stageData[0]=0xFFFF, then read r0 -> fwdSel=0, fwdData=exSrcData, no stall.
6. Load-use with stallExt=1 for 3 cycles -> entries and count frozen, hazardStall=1 throughout, count unchanged.
   - Then flush=1 -> hazardStall=0 and a bubble enters.
   - A separate run asserts rst mid-stall -> immediate clear.
   - With COUNT_W=2, 4 stall cycles -> stallCount saturates at 3.
